// File: rtl/dp_ram_be_clr.sv
// True dual-port single-clock RAM with byte enables, optional output register,
// selectable same-port read-during-write policy, collision flag and post-reset zero-fill.
module dp_ram_be_clr #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned OUT_REG        = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cea,
  input  logic                  wrea,
  input  logic [DATA_W/8-1:0]   bea,
  input  logic [ADDR_W-1:0]     ada,
  input  logic [DATA_W-1:0]     dina,
  output logic [DATA_W-1:0]     douta,
  input  logic                  ceb,
  input  logic                  wreb,
  input  logic [DATA_W/8-1:0]   beb,
  input  logic [ADDR_W-1:0]     adb,
  input  logic [DATA_W-1:0]     dinb,
  output logic [DATA_W-1:0]     doutb,
  output logic                  init_busy,
  output logic                  collision
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_addr, w_clr_addr_nxt;
  logic                r_init_busy, w_init_busy_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_s1_a, r_s1_b;
  logic                r_collision;

  logic                w_ena, w_enb, w_wra, w_wrb, w_same;
  logic [DATA_W-1:0]   w_old_a, w_old_b, w_fin_a, w_fin_b, w_rd_a, w_rd_b;

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] din,
                                                input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = din[8*i +: 8];
    end
    return res;
  endfunction

  // Clear sequencer state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      r_clr_addr  <= '0;
      r_init_busy <= (CLEAR_ON_RESET != 0);
    end else begin
      r_state     <= w_state_nxt;
      r_clr_addr  <= w_clr_addr_nxt;
      r_init_busy <= w_init_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_clr_addr_nxt  = r_clr_addr;
    w_init_busy_nxt = r_init_busy;
    case (r_state)
      S_CLEAR: begin
        w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
        if (r_clr_addr == {ADDR_W{1'b1}}) begin
          w_state_nxt     = S_IDLE;
          w_init_busy_nxt = 1'b0;
        end
      end
      S_IDLE:  w_init_busy_nxt = 1'b0;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_ena   = cea & resetn & (r_state == S_IDLE);
  assign w_enb   = ceb & resetn & (r_state == S_IDLE);
  assign w_wra   = w_ena & wrea & (|bea);
  assign w_wrb   = w_enb & wreb & (|beb);
  assign w_same  = (ada == adb);
  assign w_old_a = r_mem[ada];
  assign w_old_b = r_mem[adb];

  // Word each port's address will hold after this edge; A overrides B on shared bytes
  always_comb begin
    w_fin_a = w_old_a;
    w_fin_b = w_old_b;
    if (w_wrb && w_same) w_fin_a = f_merge(w_fin_a, dinb, beb);
    if (w_wra)           w_fin_a = f_merge(w_fin_a, dina, bea);
    if (w_wrb)           w_fin_b = f_merge(w_fin_b, dinb, beb);
    if (w_wra && w_same) w_fin_b = f_merge(w_fin_b, dina, bea);
  end

  assign w_rd_a = ((RDW_MODE != 0) && w_wra) ? w_fin_a : w_old_a;
  assign w_rd_b = ((RDW_MODE != 0) && w_wrb) ? w_fin_b : w_old_b;

  always_ff @(posedge clk) begin
    if (resetn && (r_state == S_CLEAR)) begin
      r_mem[r_clr_addr] <= '0;
    end else begin
      if (w_wra) r_mem[ada] <= w_fin_a;
      if (w_wrb) r_mem[adb] <= w_fin_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_collision <= 1'b0;
    end else begin
      if (w_ena) r_s1_a <= w_rd_a;
      if (w_enb) r_s1_b <= w_rd_b;
      r_collision <= w_ena & w_enb & w_same & (wrea | wreb);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              r_ce_a, r_ce_b;
      logic [DATA_W-1:0] r_dout_a, r_dout_b;
      always_ff @(posedge clk) begin
        if (!resetn) begin
          r_ce_a   <= 1'b0;
          r_ce_b   <= 1'b0;
          r_dout_a <= '0;
          r_dout_b <= '0;
        end else begin
          r_ce_a <= w_ena;
          r_ce_b <= w_enb;
          if (r_ce_a) r_dout_a <= r_s1_a;
          if (r_ce_b) r_dout_b <= r_s1_b;
        end
      end
      assign douta = r_dout_a;
      assign doutb = r_dout_b;
    end else begin : g_no_out_reg
      assign douta = r_s1_a;
      assign doutb = r_s1_b;
    end
  endgenerate

  assign init_busy = r_init_busy;
  assign collision = r_collision;

endmodule
